// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: fills the register bank, data memory and instruction
// memory from a 32-bit header/payload word stream, then releases the datapath.
// Every output is registered. Write strobes are one-cycle pulses that follow
// the accepting edge.
module boot_loader_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              rb_we_o,
  output logic              dm_we_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] ld_addr_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              busy_o,
  output logic              dp_run_o,
  output logic              error_o
);

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_RUN    = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [1:0] TGT_RB  = 2'b00;
  localparam logic [1:0] TGT_DM  = 2'b01;
  localparam logic [1:0] TGT_IM  = 2'b10;
  localparam logic [1:0] TGT_END = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [13:0]       rem_q, rem_d;

  logic              rb_we_q, rb_we_d;
  logic              dm_we_q, dm_we_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              dp_run_q, dp_run_d;
  logic              error_q, error_d;

  // Header fields. The stream is only consumed while in_ready_q is high, so
  // a transfer never depends combinationally on anything but registered state.
  logic              xfer;
  logic [1:0]        hdr_tgt;
  logic [13:0]       hdr_cnt;
  logic [ADDR_W-1:0] hdr_base;

  assign xfer     = in_valid_i && in_ready_q;
  assign hdr_tgt  = in_data_i[31:30];
  assign hdr_cnt  = in_data_i[29:16];
  assign hdr_base = in_data_i[ADDR_W-1:0];

  // Next-state logic: header decode, payload write generation, terminal states.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rb_we_d   = 1'b0;
    dm_we_d   = 1'b0;
    im_we_d   = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    unique case (state_q)
      S_HEADER: begin
        if (xfer) begin
          if (hdr_tgt == TGT_END) begin
            state_d = S_RUN;
          end else if (hdr_cnt == 14'd0) begin
            state_d = S_ERROR;
          end else begin
            tgt_d   = hdr_tgt;
            addr_d  = hdr_base;
            rem_d   = hdr_cnt;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          rb_we_d   = (tgt_q == TGT_RB);
          dm_we_d   = (tgt_q == TGT_DM);
          im_we_d   = (tgt_q == TGT_IM);
          ld_addr_d = addr_q;
          ld_data_d = in_data_i;
          // Address wraps naturally at 2^ADDR_W; the register bank only
          // looks at the low five bits, so it wraps at 32.
          addr_d    = addr_q + ADDR_ONE;
          rem_d     = rem_q - 14'd1;
          if (rem_q == 14'd1) state_d = S_HEADER;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_HEADER;
    endcase
  end

  // Status outputs are decodes of the next state, registered so they line up
  // with the state they describe.
  always_comb begin
    in_ready_d = (state_d == S_HEADER) || (state_d == S_DATA);
    busy_d     = (state_d == S_DATA);
    dp_run_d   = (state_d == S_RUN);
    error_d    = (state_d == S_ERROR);
  end

  // State, counters and output registers; reset abandons any partial block.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_HEADER;
      tgt_q      <= TGT_RB;
      addr_q     <= '0;
      rem_q      <= '0;
      rb_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      im_we_q    <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      dp_run_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rb_we_q    <= rb_we_d;
      dm_we_q    <= dm_we_d;
      im_we_q    <= im_we_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      dp_run_q   <= dp_run_d;
      error_q    <= error_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign rb_we_o    = rb_we_q;
  assign dm_we_o    = dm_we_q;
  assign im_we_o    = im_we_q;
  assign ld_addr_o  = ld_addr_q;
  assign ld_data_o  = ld_data_q;
  assign busy_o     = busy_q;
  assign dp_run_o   = dp_run_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed and random word streams, a stream-level
// reference model that queues expected writes, and a monitor that pops them.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, rb_we, dm_we, im_we, busy, dp_run, error;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  boot_loader_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .rb_we_o(rb_we), .dm_we_o(dm_we), .im_we_o(im_we),
    .ld_addr_o(ld_addr), .ld_data_o(ld_data), .busy_o(busy),
    .dp_run_o(dp_run), .error_o(error)
  );

  typedef struct {
    int          tgt;
    int          addr;
    logic [31:0] data;
    longint      t;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  // Reference model of the stream: words left in the current block, where the
  // next payload word lands, and whether the loader has finished or failed.
  int  m_rem   = 0;
  int  m_tgt   = 0;
  int  m_addr  = 0;
  bit  m_run   = 0;
  bit  m_err   = 0;
  bit  m_inrst = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic consume(input logic [31:0] w, input longint t);
    wr_t e;
    if (m_rem == 0) begin
      if (w[31:30] == 2'b11) m_run = 1;
      else if (w[29:16] == 14'd0) m_err = 1;
      else begin
        m_tgt  = int'(w[31:30]);
        m_rem  = int'(w[29:16]);
        m_addr = int'(w[15:0]) % 256;
      end
    end else begin
      e.tgt = m_tgt; e.addr = m_addr; e.data = w; e.t = t;
      exp_q.push_back(e);
      m_addr = (m_addr + 1) % 256;
      m_rem  = m_rem - 1;
    end
  endtask

  // One clock cycle of stimulus, then a status check against the model.
  task automatic step(input bit v, input logic [31:0] d);
    bit acc;
    in_valid = v;
    in_data  = d;
    acc = v && rst_n && !m_inrst && !m_run && !m_err;
    @(posedge clk);
    if (!rst_n) begin
      m_rem = 0; m_run = 0; m_err = 0; m_inrst = 1;
    end else begin
      m_inrst = 0;
      if (acc) consume(d, $time);
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_inrst && !m_run && !m_err));
    chk("busy",     32'(busy),     32'(m_rem > 0));
    chk("dp_run",   32'(dp_run),   32'(m_run));
    chk("error",    32'(error),    32'(m_err));
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    repeat (gap) step(1'b0, $urandom);
    step(1'b1, w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("rst_strobes", 32'({rb_we, dm_we, im_we}), 32'h0);
    chk("rst_ld_addr", 32'(ld_addr), 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    rst_n = 1'b1;
    step(1'b0, 32'h0);
  endtask

  task automatic rand_stream(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      if (m_rem == 0) begin
        w[31:30] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        w[29:16] = ($urandom_range(0, 20) == 0) ? 14'd0 : 14'($urandom_range(1, 6));
        w[15:0]  = 16'($urandom_range(0, 65535));
      end else begin
        w = $urandom;
      end
      step($urandom_range(0, 3) != 0, w);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, arrive
  // in the cycle right after acceptance, and be the only strobe high.
  longint mon_t;
  wr_t    mon_e;
  always @(posedge clk) begin
    mon_t = $time;
    #1;
    if (rb_we || dm_we || im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: strobes %b addr %0h data %0h at %0t",
                 {rb_we, dm_we, im_we}, ld_addr, ld_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_target", 32'({rb_we, dm_we, im_we}),
            (mon_e.tgt == 0) ? 32'h4 : (mon_e.tgt == 1) ? 32'h2 : 32'h1);
        chk("wr_time", 32'(mon_t), 32'(mon_e.t));
        chk("wr_addr", (mon_e.tgt == 0) ? 32'(ld_addr[4:0]) : 32'(ld_addr),
            (mon_e.tgt == 0) ? 32'(mon_e.addr % 32) : 32'(mon_e.addr));
        chk("wr_data", ld_data, mon_e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    do_reset();

    // Register load, back-to-back.
    send(32'h0003_0005, 0);
    send(32'h0000_000A, 0); send(32'h0000_000B, 0); send(32'h0000_000C, 0);

    // Register-bank and instruction-memory address wrap.
    send(32'h0004_001E, 0);
    for (int i = 0; i < 4; i++) send($urandom, 0);
    send(32'h8002_00FF, 0);
    send(32'h1111_2222, 0); send(32'h3333_4444, 0);

    // Data memory with 3-cycle gaps between payload words.
    send(32'h4002_0010, 0);
    send(32'hDEAD_BEEF, 3); send(32'hCAFE_F00D, 3);

    // Random blocks, then END; later words must be ignored.
    for (int b = 0; b < 6; b++) begin
      send({2'($urandom_range(0, 2)), 14'($urandom_range(1, 6)), 16'($urandom)}, 0);
      while (m_rem > 0) send($urandom, $urandom_range(0, 2));
    end
    send(32'hC000_0000, 0);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom);

    // Zero-count header goes to the error state; reset clears it.
    do_reset();
    send(32'h4000_0020, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0003_0001);
    do_reset();

    // Reset in the middle of an instruction-memory block.
    send(32'h8004_0030, 0);
    send(32'h0000_0001, 0); send(32'h0000_0002, 0);
    do_reset();
    send(32'hC000_0000, 0);
    step(1'b0, 32'h0);

    // Fully random streams.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_stream(60);
    end

    repeat (3) step(1'b0, 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
